if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined LC-3b core. It owns the PC, runs the instruction-memory read handshake and presents {incremented PC, instruction word} with a valid flag.
- Its outputs feed the IF/ID pipeline register.
- It honours backpressure (stall from ID/hazard logic) and control-flow redirects from later stages, including discarding an in-flight fetch.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_in  in  1  downstream cannot accept; held instruction must persist.
- redirect  in  1  taken branch/JMP/JSR/TRAP from a later stage; squash and refetch.
- redirect_pc  in  16 (lc3b_word)  new fetch address; bit 0 forced to 0.
- imem_read  out  1  instruction-memory read request.
- imem_address  out  16  instruction-memory address.
- imem_rdata  in  16  instruction-memory read data; valid when imem_resp=1.
- imem_resp  in  1  instruction-memory response, one-cycle pulse.
- pc_out  out  16  fetched address + 2; drives pc_ID_in of IF/ID.
- ir_out  out  16  fetched instruction; drives ir_in of IF/ID.
- valid_out  out  1  pc_out/ir_out hold a live instruction; IF/ID load = valid_out & ~stall_in.

Behaviour:

Reset:
- Asynchronous assert: state=FETCH, pc=RESET_PC, req_addr=0, pc_buf=0, ir_buf=0.
- While reset=1: imem_read=0, valid_out=0.
- First read is issued in the cycle after reset deasserts.
- Reset mid-request aborts the request; a stray imem_resp arriving after reset is not expected. The bench must not generate one.

Memory protocol:
- Once imem_read rises, imem_read and imem_address stay constant until the cycle in which imem_resp=1.
- A request is never withdrawn.

States:
- FETCH
  - imem_read=1, imem_address=pc, valid_out=0.
  - imem_resp & ~redirect: ir_buf<=imem_rdata; pc_buf<=pc+2; pc<=pc+2; go to HOLD.
  - imem_resp & redirect: drop data; pc<=redirect_pc; stay in FETCH (new request next cycle).
  - ~imem_resp & redirect: req_addr<=pc; pc<=redirect_pc; go to DISCARD.
  - Otherwise stay in FETCH.
- DISCARD
  - imem_read=1, imem_address=req_addr, valid_out=0.
  - redirect: pc<=redirect_pc; stay in DISCARD.
  - imem_resp: data dropped; go to FETCH. If redirect occurs in the same cycle, the redirect pc is taken.
- HOLD
  - imem_read=0, valid_out = ~redirect (combinational squash), pc_out=pc_buf, ir_out=ir_buf.
  - redirect: pc<=redirect_pc; go to FETCH. The held instruction is discarded even if stall_in=0.
  - ~stall_in & ~redirect: instruction consumed this cycle; go to FETCH.
  - stall_in & ~redirect: stay in HOLD; outputs unchanged.

Outputs and timing:
- pc_out/ir_out come from registers and are stable for the whole HOLD interval.
- Latency from imem_resp to valid_out=1 is 1 cycle.
- Steady-state throughput is one instruction per (memory latency + 2) cycles.

Arithmetic:
- pc+2 is modulo 2^16: 16'hFFFE -> 16'h0000.
- pc is always even.

Priority: reset > redirect > imem_resp > stall_in.

Decomposition:
- Use lc3b_word from lc3b_types.
- Add the state enum lc3b_fetch_state {FETCH, DISCARD, HOLD} to lc3b_types.
- Reuse the existing register_with_clear for pc_buf and ir_buf only if an async-reset variant exists. Otherwise write a new sub-module, register_async_reset, and use it for pc, req_addr, pc_buf and ir_buf.
- Keep the FSM in this module.

Test Plan:
1. Reset, then 1-cycle-latency memory returning 16'h1234 at address 0 -> imem_address=0, then valid_out=1 with pc_out=16'h0002 and ir_out=16'h1234; next fetch is at 16'h0002.
2. stall_in=1 for 3 cycles while in HOLD -> valid_out, pc_out and ir_out unchanged; imem_read=0; no PC advance. Release -> next request at pc+2.
3. redirect to 16'h3001 while a 3-cycle read of 16'h0004 is outstanding -> imem_address stays 16'h0004 until resp; data discarded, valid_out never 1; next request at 16'h3000.
4. redirect to 16'h0040 in the same cycle as imem_resp -> data dropped, no HOLD; next cycle imem_address=16'h0040.
5. RESET_PC=16'hFFFE, fetch completes -> pc_out=16'h0000 and next imem_address=16'h0000.
6. Assert reset during DISCARD and again in HOLD -> outputs immediately 0 and valid_out=0; the first request after release is at RESET_PC.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, fetch FSM state, address helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DISCARD = 2'd1,
      HOLD    = 2'd2
   } lc3b_fetch_state;

   // Instructions are 16-bit, so sequential fetch advances by one word.
   localparam lc3b_word PC_INC = 16'd2;

   // Fetch addresses are always word aligned; bit 0 is cleared.
   function automatic lc3b_word even_addr(input lc3b_word a);
      return a & 16'hFFFE;
   endfunction

endpackage

// File: rtl/register_async_reset.sv
// Loadable register with asynchronous active-high reset to a fixed value.
// Latency: 1 cycle from load to q.
// Backpressure: none; holds its value whenever load is low.
module register_async_reset #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d on load; reset forces RESET_VAL immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= RESET_VAL;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/if_fetch_stage.sv
// LC-3b instruction fetch: owns the PC, runs the imem handshake, presents {pc+2, ir}.
// Latency: valid_out rises 1 cycle after imem_resp; one instruction per (mem latency + 2) cycles.
// Backpressure: stall_in holds the fetched instruction in HOLD; redirect squashes and refetches.
module if_fetch_stage
   import lc3b_types::*;
#(
   parameter lc3b_word RESET_PC = 16'h0000
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     stall_in,
   input  logic     redirect,
   input  lc3b_word redirect_pc,
   output logic     imem_read,
   output lc3b_word imem_address,
   input  lc3b_word imem_rdata,
   input  logic     imem_resp,
   output lc3b_word pc_out,
   output lc3b_word ir_out,
   output logic     valid_out
);

   lc3b_fetch_state state, state_next;

   lc3b_word pc, pc_d, pc_plus2, redirect_tgt;
   lc3b_word req_addr, pc_buf, ir_buf;
   logic     pc_ld, req_ld, buf_ld;

   assign pc_plus2     = pc + PC_INC;
   assign redirect_tgt = even_addr(redirect_pc);

   // pc: next fetch address (sequential or redirect target).
   register_async_reset #(.WIDTH(16), .RESET_VAL(RESET_PC)) u_pc (
      .clk(clk), .reset(reset), .load(pc_ld), .d(pc_d), .q(pc)
   );

   // req_addr: address of the outstanding request being discarded; the
   // memory protocol forbids changing imem_address before its response.
   register_async_reset #(.WIDTH(16), .RESET_VAL(16'h0000)) u_req_addr (
      .clk(clk), .reset(reset), .load(req_ld), .d(pc), .q(req_addr)
   );

   register_async_reset #(.WIDTH(16), .RESET_VAL(16'h0000)) u_pc_buf (
      .clk(clk), .reset(reset), .load(buf_ld), .d(pc_plus2), .q(pc_buf)
   );

   register_async_reset #(.WIDTH(16), .RESET_VAL(16'h0000)) u_ir_buf (
      .clk(clk), .reset(reset), .load(buf_ld), .d(imem_rdata), .q(ir_buf)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= FETCH;
      else
         state <= state_next;
   end

   // Next state and register updates; redirect outranks imem_resp outranks stall_in.
   always_comb begin
      state_next = state;
      pc_ld      = 1'b0;
      pc_d       = pc_plus2;
      req_ld     = 1'b0;
      buf_ld     = 1'b0;
      case (state)
         FETCH: begin
            if (redirect) begin
               pc_ld = 1'b1;
               pc_d  = redirect_tgt;
               // Request still in flight: remember its address and drain it.
               if (!imem_resp) begin
                  req_ld     = 1'b1;
                  state_next = DISCARD;
               end
            end else if (imem_resp) begin
               pc_ld      = 1'b1;
               buf_ld     = 1'b1;
               state_next = HOLD;
            end
         end
         DISCARD: begin
            if (redirect) begin
               pc_ld = 1'b1;
               pc_d  = redirect_tgt;
            end
            if (imem_resp)
               state_next = FETCH;
         end
         HOLD: begin
            if (redirect) begin
               pc_ld      = 1'b1;
               pc_d       = redirect_tgt;
               state_next = FETCH;
            end else if (!stall_in) begin
               state_next = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

   // Outputs; reset gates the request and valid so nothing leaks while held.
   always_comb begin
      imem_read    = 1'b0;
      imem_address = pc;
      valid_out    = 1'b0;
      case (state)
         FETCH:   imem_read = ~reset;
         DISCARD: begin
            imem_read    = ~reset;
            imem_address = req_addr;
         end
         HOLD:    valid_out = ~reset & ~redirect;
         default: ;
      endcase
   end

   assign pc_out = pc_buf;
   assign ir_out = ir_buf;

endmodule
